// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial W-bit adder that time-shares one half adder,
// using two passes per bit, with valid/ready handshakes on input and output.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out
);
  localparam int IW = W > 1 ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic cy_q, cy_d, s1_q, s1_d, c1_q, c1_d, pre_q, pre_d;
  logic ha_a, ha_b, ha_s, ha_c;
  half_adder u_ha (.a(ha_a), .b(ha_b), .s(ha_s), .c(ha_c));
  assign in_ready  = state_q == IDLE && !abort;
  assign out_valid = state_q == DONE;
  assign sum       = out_valid ? sum_q : '0;
  assign carry_out = out_valid & cy_q;
  always_comb begin
    ha_a = state_q == PASS1 ? a_q[idx_q] : state_q == PASS2 ? s1_q : 1'b0;
    ha_b = state_q == PASS1 ? b_q[idx_q] : state_q == PASS2 ? cy_q : 1'b0;
  end
  // pre_q holds PASS1 for one extra cycle after accept so bit i starts PASS1 at edge k+1+2i
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    s1_d    = s1_q;
    c1_d    = c1_q;
    pre_d   = pre_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        a_d     = op_a;
        b_d     = op_b;
        idx_d   = '0;
        cy_d    = 1'b0;
        sum_d   = '0;
        pre_d   = 1'b1;
        state_d = PASS1;
      end
      PASS1: begin
        s1_d    = ha_s;
        c1_d    = ha_c;
        pre_d   = 1'b0;
        state_d = abort ? IDLE : pre_q ? PASS1 : PASS2;
      end
      PASS2: begin
        sum_d[idx_q] = ha_s;
        cy_d         = c1_q | ha_c;
        if (abort) state_d = IDLE;
        else if (idx_q == IW'(W - 1)) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = PASS1;
        end
      end
      DONE: state_d = out_ready || abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      s1_q    <= s1_d;
      c1_q    <= c1_d;
      pre_q   <= pre_d;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the serial adder at W=8 and W=1.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [7:0] op_a = '0, op_b = '0;
  logic in_ready, out_valid, carry_out;
  logic [7:0] sum;
  logic v1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic r1, ov1, s1, c1;
  int pass_n = 0, total_n = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
  );

  serial_adder_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .op_a(a1), .op_b(b1), .abort(1'b0), .out_valid(ov1),
    .out_ready(1'b1), .sum(s1), .carry_out(c1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_n++;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es, input logic ec);
    int n;
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 8'hA5; op_b = 8'h5A;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_w8", n, 17);
    chk("sum_w8", sum, es);
    chk("carry_w8", carry_out, ec);
    @(posedge clk); #1;
    chk("idle_after_done", {in_ready, out_valid, sum}, {1'b1, 1'b0, 8'h00});
  endtask

  task automatic run1(input logic a, input logic b, input logic es, input logic ec);
    int n;
    @(negedge clk);
    v1 = 1'b1; a1 = a; b1 = b;
    @(posedge clk); #1;
    v1 = 1'b0; a1 = ~a; b1 = ~b;
    n = 0;
    while (!ov1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_w1", n, 3);
    chk("result_w1", {s1, c1}, {es, ec});
    @(posedge clk); #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    bit seen;
    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8'h37, 8'h48, 8'h7F, 1'b0};
    #12;
    chk("reset_outputs", {in_ready, out_valid, carry_out, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);

    // backpressure: result held, input ignored
    out_ready = 1'b0;
    start8(8'h5A, 8'h3C);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", n, 17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = 8'h11; op_b = 8'h22;
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, carry_out, sum}, {1'b1, 1'b0, 1'b0, 8'h96});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});

    // abort in PASS2 of bit 3
    start8(8'hFF, 8'hFF);
    repeat (8) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    chk("abort_blocks_ready", in_ready, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk("abort_idle", {in_ready, out_valid, sum}, {1'b1, 1'b0, 8'h00});
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    run8(8'h01, 8'h02, 8'h03, 1'b0);

    // abort in DONE without out_ready discards
    out_ready = 1'b0;
    start8(8'h0F, 8'h01);
    repeat (17) @(posedge clk);
    #1;
    chk("done_before_abort", {out_valid, sum}, {1'b1, 8'h10});
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b1;
    #1;
    chk("done_abort_idle", {out_valid, in_ready}, {1'b0, 1'b1});

    // async reset during PASS1 of bit 5
    start8(8'hAA, 8'h55);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pass1", {in_ready, out_valid, carry_out, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
    #1;
    rst_n = 1'b1;
    run8(8'h10, 8'h20, 8'h30, 1'b0);

    // async reset while holding a result in DONE
    out_ready = 1'b0;
    start8(8'hF0, 8'h20);
    repeat (17) @(posedge clk);
    #2;
    chk("done_hold", {out_valid, carry_out, sum}, {1'b1, 1'b1, 8'h10});
    rst_n = 1'b0;
    #1;
    chk("rst_done_async", {in_ready, out_valid, carry_out, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
    #1;
    rst_n = 1'b1; out_ready = 1'b1;

    run1(1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
